prog_lut_bank: RTL and testbench
================================

# prog_lut_bank

Bank of CHANNELS runtime-programmable K-input lookup tables for the iCEstick fabric. Each channel synchronises raw K-bit pin inputs, looks up an output in its truth table and registers the result. Truth tables are loaded serially into a shadow register and then committed atomically, so the bank can be reprogrammed without resynthesis. It sits between the J1 header input pads and the LED or output pads.

## Interface
- CHANNELS, 4: number of independent LUT channels.
- K, 4: inputs per LUT; each table is 2^K bits.
- SYNC_STAGES, 2: flip-flop stages on each input bit; minimum 2.
- DEFAULT_INIT, 16'h8888: per-channel table loaded at reset. Bit width is 2^K. 16'h8888 is I0 AND I1.
- CLKIN  in  1  sole clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- lut_in  in  CHANNELS*K  raw pad inputs; channel c uses [c*K +: K], bit 0 is I0.
- lut_out  out  CHANNELS  registered LUT outputs.
- cfg_shift  in  1  when high, shift cfg_data into the shadow register this cycle.
- cfg_data  in  1  serial table bit.
- cfg_commit  in  1  single-cycle request to copy shadow to active.
- cfg_done  out  1  one-cycle pulse after a successful commit.
- cfg_err  out  1  sticky flag set by a rejected commit; cleared by the next successful commit.

## Operation
- TOTAL = CHANNELS*2^K.
- Shadow register:
  - Shifts right on cfg_shift: shadow <= {cfg_data, shadow[TOTAL-1:1]}.
  - After TOTAL shifts, the first bit sent sits at shadow[0], which is channel 0 table bit 0.
  - Channel c table = [c*2^K +: 2^K].
- Lookup: lut_out[c] <= active_c[sync_in_c], where sync_in_c is the synchronised K-bit index for channel c.
- Bit counter cnt, 0..TOTAL+1, saturating at TOTAL+1. Load FSM is derived from cnt:
  - IDLE (cnt=0): cfg_shift -> LOAD, or -> FULL if TOTAL=1.
  - LOAD (0<cnt<TOTAL): each shift increments cnt; reaching TOTAL -> FULL.
  - FULL (cnt=TOTAL): a further shift -> OVER.
  - OVER (cnt=TOTAL+1): further shifts keep moving data; cnt stays saturated.
- Commit in FULL: active <= shadow; cfg_done pulses; cfg_err <= 0; cnt <= 0; shadow is retained.
- Commit in any other state: active is unchanged; cfg_err <= 1; cnt <= 0.
- cfg_shift and cfg_commit in the same cycle: the commit is evaluated on the pre-shift cnt and shadow. The shift bit is discarded.
- Reset (asynchronous, any time, including mid-load):
  - active = DEFAULT_INIT replicated into every channel.
  - shadow, cnt, sync flops, lut_out, cfg_done and cfg_err all cleared to 0.

## Timing
- Pin-to-output latency is SYNC_STAGES+1 cycles (3 at default): synchroniser stages plus the output register.
- Commit edge n: active updates at edge n; cfg_done is high during cycle n+1. lut_out reflects the new table from edge n+1, for inputs already synchronised.
- cfg_err updates at the same edge as a rejected commit.
- No handshake back-pressure. cfg_shift is accepted every cycle it is high; back-to-back shifts are allowed.
- cfg inputs are synchronous to CLKIN; the driver guarantees this.

## Structure
- Package prog_lut_pkg holds:
  - TOTAL computation function.
  - FSM state encodings: IDLE, LOAD, FULL, OVER.
  - Default-init replication helper.
- Sub-module lut_channel, instantiated CHANNELS times. It contains:
  - K-bit SYNC_STAGES-deep synchroniser.
  - 2^K-bit active table register.
  - Mux and output flop.
- Top level owns the shadow register, counter/FSM and commit logic.

## Test plan
All scenarios use CHANNELS=2, K=4, TOTAL=32.
- Reset defaults: release RESETN, drive ch0 = 4'b0011 -> lut_out[0]=1 after 3 cycles; then drive 4'b0001 -> lut_out[0]=0 after 3 cycles. Same check on ch1.
- Full load: shift 32 bits giving ch0=16'h6666 (XOR) and ch1=16'hFFFE (OR), then commit -> cfg_done pulses once, cfg_err=0. Then ch0 in=4'b0011 -> 0, 4'b0001 -> 1; ch1 in=4'b0000 -> 0, 4'b0100 -> 1.
- Short load: 31 shifts then commit -> cfg_err=1, no cfg_done, tables still DEFAULT_INIT. A following correct 32-bit load and commit -> cfg_err=0.
- Overflow: 33 shifts then commit -> rejected, cfg_err=1, cnt=0, tables unchanged.
- Reset mid-load: after 10 shifts assert RESETN low for 1 cycle. Then 32 fresh shifts and commit succeed, and the loaded table matches only the 32 bits sent after reset.
- Simultaneous: 32nd bit applied with cfg_shift and cfg_commit together -> commit rejected (pre-shift cnt=31), cfg_err=1, that bit discarded.

Source files
------------

// File: rtl/prog_lut_pkg.sv
// Shared definitions for the programmable LUT bank.
// Holds the table-size arithmetic, the load FSM state type and the helper
// that replicates one per-channel init table into a full bank image.
package prog_lut_pkg;

  // Upper bound on bank image width handled by the replication helper.
  localparam int unsigned MaxTotal = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFull,
    StOver
  } load_state_e;

  // Total number of truth-table bits across the bank.
  function automatic int unsigned total_bits(input int unsigned channels,
                                             input int unsigned k);
    return channels * (32'd1 << k);
  endfunction

  // Copy the low table_bits of init into every channel slot of the image.
  function automatic logic [MaxTotal-1:0] replicate_init(input logic [MaxTotal-1:0] init,
                                                         input int unsigned channels,
                                                         input int unsigned table_bits);
    logic [MaxTotal-1:0] img;
    img = '0;
    for (int unsigned c = 0; c < channels; c++) begin
      for (int unsigned b = 0; b < table_bits; b++) begin
        img[c*table_bits+b] = init[b];
      end
    end
    return img;
  endfunction

endpackage

// File: rtl/prog_lut_bank_lut_channel.sv
// One LUT channel: K-bit input synchroniser, 2^K-bit active truth table and
// registered output.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   pin         - raw K-bit pad inputs (bit 0 is I0)
//   load        - copy new_table into the active table this cycle
//   new_table   - table image from the shared shadow register
//   out         - registered lookup result
module lut_channel #(
  parameter int unsigned K           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [(1<<K)-1:0] INIT  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [K-1:0]        pin,
  input  logic                load,
  input  logic [(1<<K)-1:0]   new_table,
  output logic                out
);

  logic [SYNC_STAGES-1:0][K-1:0] sync_q;
  logic [(1<<K)-1:0]             table_q;
  logic                          out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q <= INIT;
    end else if (load) begin
      table_q <= new_table;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= table_q[sync_q[SYNC_STAGES-1]];
    end
  end

  assign out = out_q;

endmodule

// File: rtl/prog_lut_bank.sv
// Bank of runtime-programmable K-input LUTs. Tables are shifted serially
// into a shadow register and committed to all channels at once.
// Ports:
//   CLKIN, RESETN - clock and asynchronous active-low reset
//   lut_in        - raw pad inputs, channel c uses [c*K +: K]
//   lut_out       - registered LUT outputs, one per channel
//   cfg_shift     - shift cfg_data into the shadow register
//   cfg_data      - serial table bit
//   cfg_commit    - request to copy shadow to active tables
//   cfg_done      - one-cycle pulse after an accepted commit
//   cfg_err       - sticky, set by a rejected commit, cleared by an accepted one
module prog_lut_bank
  import prog_lut_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned K               = 4,
  parameter int unsigned SYNC_STAGES     = 2,  // must be at least 2
  parameter logic [(1<<K)-1:0] DEFAULT_INIT = 16'h8888
) (
  input  logic                  CLKIN,
  input  logic                  RESETN,
  input  logic [CHANNELS*K-1:0] lut_in,
  output logic [CHANNELS-1:0]   lut_out,
  input  logic                  cfg_shift,
  input  logic                  cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int unsigned TableBits = 1 << K;
  localparam int unsigned TOTAL     = total_bits(CHANNELS, K);
  localparam int unsigned CntW      = $clog2(TOTAL + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(TOTAL);
  localparam logic [CntW-1:0] CntOver = CntW'(TOTAL + 1);
  localparam logic [TOTAL-1:0] InitAll =
      TOTAL'(replicate_init(MaxTotal'(DEFAULT_INIT), CHANNELS, TableBits));

  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             commit_ok;
  load_state_e      state;

  // The load state is a pure decode of the bit counter.
  always_comb begin
    state = StOver;
    if (cnt_q == '0) begin
      state = StIdle;
    end else if (cnt_q < CntFull) begin
      state = StLoad;
    end else if (cnt_q == CntFull) begin
      state = StFull;
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = err_q;
    commit_ok = 1'b0;
    if (cfg_commit) begin
      // Commit wins over a coincident shift; that shift bit is dropped.
      cnt_d = '0;
      if (state == StFull) begin
        commit_ok = 1'b1;
        done_d    = 1'b1;
        err_d     = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg_shift) begin
      shadow_d = {cfg_data, shadow_q[TOTAL-1:1]};
      unique case (state)
        StIdle, StLoad: cnt_d = cnt_q + CntW'(1);
        StFull:         cnt_d = CntOver;
        StOver:         cnt_d = CntOver;
        default:        cnt_d = CntOver;
      endcase
    end
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg_done = done_q;
  assign cfg_err  = err_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    lut_channel #(
      .K           (K),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (InitAll[c*TableBits +: TableBits])
    ) u_chan (
      .clk       (CLKIN),
      .rst_n     (RESETN),
      .pin       (lut_in[c*K +: K]),
      .load      (commit_ok),
      .new_table (shadow_q[c*TableBits +: TableBits]),
      .out       (lut_out[c])
    );
  end

endmodule

// File: tb/tb_prog_lut_bank.sv
// Self-checking bench for prog_lut_bank with CHANNELS=2, K=4.
module tb_prog_lut_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lut_in = '0;
  logic [1:0] lut_out;
  logic       cfg_shift = 1'b0;
  logic       cfg_data = 1'b0;
  logic       cfg_commit = 1'b0;
  logic       cfg_done;
  logic       cfg_err;

  always #5 clk = ~clk;

  prog_lut_bank #(
    .CHANNELS     (2),
    .K            (4),
    .SYNC_STAGES  (2),
    .DEFAULT_INIT (16'h8888)
  ) dut (
    .CLKIN      (clk),
    .RESETN     (rst_n),
    .lut_in     (lut_in),
    .lut_out    (lut_out),
    .cfg_shift  (cfg_shift),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  int total = 0;
  int bad = 0;

  // Reference model: expected tables, the bits sent since the last clear,
  // and the sticky error flag.
  logic [15:0] m_tbl[2];
  logic        m_bits[$];
  logic        m_err;

  typedef struct {
    int         phase;
    logic [3:0] i0;
    logic [3:0] i1;
    logic       e0;
    logic       e1;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tbl[0] = 16'h8888;
    m_tbl[1] = 16'h8888;
    m_bits.delete();
    m_err = 1'b0;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    cfg_shift  = 1'b0;
    cfg_commit = 1'b0;
    rst_n      = 1'b0;
    #1;
    check({name, " out async"}, 32'(lut_out), 32'd0);
    @(negedge clk);
    model_reset();
    check({name, " done"}, 32'(cfg_done), 32'd0);
    check({name, " err"}, 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; each following posedge captures one bit.
  task automatic shift_bits(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_shift = 1'b1;
      cfg_data  = d[i];
      @(negedge clk);
      m_bits.push_back(d[i]);
    end
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
  endtask

  task automatic commit(input string name, input bit with_shift, input logic b);
    bit          ok;
    logic [31:0] img;
    ok = (m_bits.size() == 32);
    cfg_commit = 1'b1;
    cfg_shift  = with_shift;
    cfg_data   = b;
    @(negedge clk);
    cfg_commit = 1'b0;
    cfg_shift  = 1'b0;
    if (ok) begin
      // The first bit sent ends at bit 0 of the bank image.
      for (int i = 0; i < 32; i++) img[i] = m_bits[i];
      m_tbl[0] = img[15:0];
      m_tbl[1] = img[31:16];
      m_err    = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    m_bits.delete();
    check({name, " done"}, 32'(cfg_done), 32'(ok));
    check({name, " err"}, 32'(cfg_err), 32'(m_err));
    @(negedge clk);
    check({name, " done pulse"}, 32'(cfg_done), 32'd0);
  endtask

  task automatic apply_in(input logic [3:0] a, input logic [3:0] b);
    lut_in = {b, a};
    repeat (3) @(negedge clk);
  endtask

  task automatic check_model(input string name);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s ch%0d in=%0h", name, c, lut_in[c*4 +: 4]),
            32'(lut_out[c]), 32'(m_tbl[c][lut_in[c*4 +: 4]]));
    end
  endtask

  task automatic run_vecs(input int phase, input string name);
    foreach (vecs[i]) begin
      if (vecs[i].phase == phase) begin
        apply_in(vecs[i].i0, vecs[i].i1);
        check($sformatf("%s v%0d ch0", name, i), 32'(lut_out[0]), 32'(vecs[i].e0));
        check($sformatf("%s v%0d ch1", name, i), 32'(lut_out[1]), 32'(vecs[i].e1));
      end
    end
  endtask

  task automatic rand_checks(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      apply_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check_model(name);
    end
  endtask

  initial begin
    logic [63:0] w;
    int          n;
    bit          sim;

    // Phase 0: default AND table. Phase 1: ch0 XOR (6666), ch1 OR (FFFE).
    vecs.push_back('{0, 4'b0011, 4'b0011, 1'b1, 1'b1});
    vecs.push_back('{0, 4'b0001, 4'b0001, 1'b0, 1'b0});
    vecs.push_back('{0, 4'b1111, 4'b0111, 1'b1, 1'b1});
    vecs.push_back('{0, 4'b1000, 4'b1011, 1'b0, 1'b1});
    vecs.push_back('{1, 4'b0011, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1, 4'b0001, 4'b0100, 1'b1, 1'b1});
    vecs.push_back('{1, 4'b0010, 4'b1000, 1'b1, 1'b1});
    vecs.push_back('{1, 4'b1111, 4'b0001, 1'b0, 1'b1});

    model_reset();
    do_reset("reset");
    run_vecs(0, "default");

    // Latency: output changes exactly three cycles after the pin.
    apply_in(4'b0011, 4'b0011);
    lut_in[3:0] = 4'b0001;
    repeat (2) @(negedge clk);
    check("latency hold", 32'(lut_out[0]), 32'd1);
    @(negedge clk);
    check("latency update", 32'(lut_out[0]), 32'd0);

    // Short load is rejected and leaves defaults.
    shift_bits({32'd0, 16'hFFFE, 16'h6666}, 31);
    commit("short", 1'b0, 1'b0);
    run_vecs(0, "after short");

    // Full load accepted.
    shift_bits({32'd0, 16'hFFFE, 16'h6666}, 32);
    commit("full", 1'b0, 1'b0);
    run_vecs(1, "loaded");

    // Overflow rejected, tables unchanged.
    shift_bits({31'd0, 1'b1, 32'h1234_5678}, 33);
    commit("over", 1'b0, 1'b0);
    run_vecs(1, "after over");

    // Reset mid-load, then only post-reset bits count.
    shift_bits(64'hFFFF_FFFF_FFFF_FFFF, 10);
    do_reset("midload");
    shift_bits({32'd0, 32'hA5C3_0FF0}, 32);
    commit("post reset", 1'b0, 1'b0);
    check("post reset tbl0", 32'(m_tbl[0]), 32'h0FF0);
    rand_checks("post reset", 4);

    // 32nd bit arrives with the commit: rejected, bit discarded.
    shift_bits({32'd0, 32'h0000_FFFF}, 31);
    commit("simul", 1'b1, 1'b1);
    rand_checks("after simul", 3);

    // Randomised loads with mixed lengths and occasional coincident commits.
    for (int it = 0; it < 16; it++) begin
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       n = 31;
        4:       n = 33;
        5:       n = 34;
        default: n = 32;
      endcase
      sim = ($urandom_range(0, 3) == 0);
      shift_bits(w, n);
      commit($sformatf("rand%0d", it), sim, 1'($urandom_range(0, 1)));
      rand_checks($sformatf("rand%0d", it), 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
